// File: rtl/vga_pkg.sv
// Shared phase constants, slot types and the slot-decode helper for the
// character-cell VRAM scheduler.
package vga_pkg;

    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_HOST_A = 3'd3;
    localparam logic [2:0] PH_HOST_B = 3'd5;
    localparam logic [2:0] PH_LOAD   = 3'd7;

    localparam int DOTS_PER_CHAR = 8;
    localparam int VRAM_AW       = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        HOST = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_ISSUED = 2'd1,
        H_DONE   = 2'd2
    } host_st_t;

    // A blanked cell hands its display slot to the host.
    function automatic slot_t slot_of(input logic [2:0] ph, input logic fetch_en);
        slot_t s;
        s = IDLE;
        if (ph == PH_FETCH) begin
            s = fetch_en ? DISP : HOST;
        end else if (ph == PH_HOST_A || ph == PH_HOST_B) begin
            s = HOST;
        end
        return s;
    endfunction

endpackage

// File: rtl/char_phase_ctr.sv
// Mod-DOTS character phase counter with per-phase slot decode and the
// registered ph2 load strobe.
module char_phase_ctr
    import vga_pkg::*;
#(
    parameter int DOTS = DOTS_PER_CHAR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_en,
    output logic [2:0] ph,
    output slot_t      slot,
    output logic       ph2
);

    localparam logic [2:0] PH_LAST = 3'(DOTS - 1);

    logic [2:0] ph_next;

    always_comb begin
        ph_next = (ph == PH_LAST) ? 3'd0 : ph + 3'd1;
    end

    // ph2 is registered from the next phase so it is high exactly while ph == PH_LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph  <= 3'd0;
            ph2 <= 1'b0;
        end else begin
            ph  <= ph_next;
            ph2 <= (ph_next == PH_LOAD);
        end
    end

    assign slot = slot_of(ph, fetch_en);

endmodule

// File: rtl/vram_sched.sv
// Character-cell scheduler sharing one single-port VRAM between the display
// fetch path and the host bus; also produces VDI, cursor and ph2.
module vram_sched
    import vga_pkg::*;
#(
    parameter int ADDR_W = VRAM_AW,
    parameter int DOTS   = DOTS_PER_CHAR
) (
    input  logic              DOTCLOCK,
    input  logic              nRESET,
    input  logic              FETCH_EN,
    input  logic [ADDR_W-1:0] MA,
    input  logic [ADDR_W-1:0] CURS_ADDR,
    input  logic              CURS_EN,
    input  logic              CURS_BLINK,
    input  logic              sec_pulse,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       DBI,
    output logic [15:0]       DBO,
    output logic              ACK,
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    input  logic [15:0]       MEM_RDATA,
    output logic              ph2,
    output logic [15:0]       VDI,
    output logic              cursor
);

    localparam logic [2:0] PH_DATA = PH_FETCH + 3'd1;

    logic [2:0]        ph;
    slot_t             slot;
    host_st_t          host_st;
    logic              host_rd;
    logic              fetch_q;
    logic [ADDR_W-1:0] ma_q;
    logic              blink;

    char_phase_ctr #(
        .DOTS (DOTS)
    ) u_ctr (
        .clk      (DOTCLOCK),
        .rst_n    (nRESET),
        .fetch_en (FETCH_EN),
        .ph       (ph),
        .slot     (slot),
        .ph2      (ph2)
    );

    // Host handshake: REQ is level-held until ACK. A host slot that samples
    // REQ=1 in H_IDLE issues the access; ACK pulses for one cycle on the next
    // edge (read data captured into DBO on that same edge). H_DONE blocks any
    // further access until REQ has been sampled low once.
    always_ff @(posedge DOTCLOCK or negedge nRESET) begin
        if (!nRESET) begin
            host_st   <= H_IDLE;
            host_rd   <= 1'b0;
            ACK       <= 1'b0;
            DBO       <= 16'h0000;
            MEM_CS    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= 16'h0000;
        end else begin
            MEM_CS <= 1'b0;
            MEM_WE <= 1'b0;
            ACK    <= 1'b0;
            case (host_st)
                H_IDLE: begin
                    if (slot == HOST && REQ) begin
                        host_st   <= H_ISSUED;
                        host_rd   <= ~WE;
                        MEM_CS    <= 1'b1;
                        MEM_WE    <= WE;
                        MEM_ADDR  <= ADDR;
                        MEM_WDATA <= DBI;
                    end
                end
                H_ISSUED: begin
                    ACK     <= 1'b1;
                    host_st <= H_DONE;
                    if (host_rd) begin
                        DBO <= MEM_RDATA;
                    end
                end
                H_DONE: begin
                    if (!REQ) begin
                        host_st <= H_IDLE;
                    end
                end
                default: host_st <= H_IDLE;
            endcase
            if (slot == DISP) begin
                MEM_CS   <= 1'b1;
                MEM_WE   <= 1'b0;
                MEM_ADDR <= MA;
            end
        end
    end

    // The fetch address is captured with the command so the cursor compare
    // refers to the cell actually being loaded, not whatever MA shows later.
    always_ff @(posedge DOTCLOCK or negedge nRESET) begin
        if (!nRESET) begin
            fetch_q <= 1'b0;
            ma_q    <= '0;
            VDI     <= 16'h0000;
            cursor  <= 1'b0;
            blink   <= 1'b1;
        end else begin
            blink <= blink ^ sec_pulse;
            if (ph == PH_FETCH) begin
                fetch_q <= (slot == DISP);
                ma_q    <= MA;
            end
            if (ph == PH_DATA) begin
                VDI    <= fetch_q ? MEM_RDATA : 16'h0000;
                cursor <= fetch_q & CURS_EN & (ma_q == CURS_ADDR) & (blink | ~CURS_BLINK);
            end
        end
    end

endmodule

// File: tb/tb_vram_sched.sv
// Directed bench for vram_sched: a spec-level cell/slot model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_vram_sched;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          nRESET = 1'b0;
    logic          FETCH_EN = 1'b1;
    logic [AW-1:0] MA = '0;
    logic [AW-1:0] CURS_ADDR = '0;
    logic          CURS_EN = 1'b0;
    logic          CURS_BLINK = 1'b1;
    logic          sec_pulse = 1'b0;
    logic          REQ = 1'b0;
    logic          WE = 1'b0;
    logic [AW-1:0] ADDR = '0;
    logic [15:0]   DBI = 16'h0000;
    logic [15:0]   DBO;
    logic          ACK;
    logic          MEM_CS;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [15:0]   MEM_WDATA;
    logic [15:0]   MEM_RDATA;
    logic          ph2;
    logic [15:0]   VDI;
    logic          cursor;

    int n_checks = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vram_sched #(.ADDR_W(AW), .DOTS(8)) dut (
        .DOTCLOCK   (clk),
        .nRESET     (nRESET),
        .FETCH_EN   (FETCH_EN),
        .MA         (MA),
        .CURS_ADDR  (CURS_ADDR),
        .CURS_EN    (CURS_EN),
        .CURS_BLINK (CURS_BLINK),
        .sec_pulse  (sec_pulse),
        .REQ        (REQ),
        .WE         (WE),
        .ADDR       (ADDR),
        .DBI        (DBI),
        .DBO        (DBO),
        .ACK        (ACK),
        .MEM_CS     (MEM_CS),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .ph2        (ph2),
        .VDI        (VDI),
        .cursor     (cursor)
    );

    // VRAM: command registered by the DUT, read data valid during the cycle
    // the read command is presented; anything else returns a junk pattern.
    logic [15:0] vram   [0:(1<<AW)-1];
    logic [15:0] shadow [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (MEM_CS && MEM_WE) vram[MEM_ADDR] <= MEM_WDATA;
    end
    assign MEM_RDATA = (MEM_CS && !MEM_WE) ? vram[MEM_ADDR] : 16'hA5C3;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int            m_ph = 0;
    logic          m_blink = 1'b1;
    logic          m_fvalid = 1'b0;
    logic [AW-1:0] m_fma = '0;
    logic [15:0]   m_fdata = 16'h0000;
    logic          m_issued = 1'b0;
    logic          m_issued_rd = 1'b0;
    logic          m_done = 1'b0;
    logic [15:0]   m_rd_data = 16'h0000;
    logic          ack_is_rd = 1'b0;
    logic          e_cs = 1'b0, e_we = 1'b0, e_ack = 1'b0, e_ph2 = 1'b0, e_cursor = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [15:0]   e_wdata = 16'h0000, e_vdi = 16'h0000, e_dbo = 16'h0000;
    logic [15:0]   exp_q[$];

    always @(posedge clk or negedge nRESET) begin
        int p;
        if (!nRESET) begin
            m_ph = 0; m_blink = 1'b1; m_fvalid = 1'b0; m_fma = '0; m_fdata = 16'h0000;
            m_issued = 1'b0; m_issued_rd = 1'b0; m_done = 1'b0; ack_is_rd = 1'b0;
            e_cs = 1'b0; e_we = 1'b0; e_ack = 1'b0; e_ph2 = 1'b0; e_cursor = 1'b0;
            e_addr = '0; e_wdata = 16'h0000; e_vdi = 16'h0000; e_dbo = 16'h0000;
            exp_q.delete();
        end else begin
            p = m_ph;
            e_cs = 1'b0; e_we = 1'b0; e_ack = 1'b0; ack_is_rd = 1'b0;
            if (p == 1) begin
                e_vdi    = m_fvalid ? m_fdata : 16'h0000;
                e_cursor = m_fvalid && CURS_EN && (m_fma == CURS_ADDR) && (m_blink || !CURS_BLINK);
            end
            if (p == 0) begin
                m_fvalid = FETCH_EN;
                if (FETCH_EN) begin
                    m_fma = MA; m_fdata = shadow[MA];
                    e_cs = 1'b1; e_addr = MA;
                end
            end
            if (m_issued) begin
                e_ack = 1'b1; ack_is_rd = m_issued_rd;
                if (m_issued_rd) e_dbo = m_rd_data;
                m_issued = 1'b0; m_done = 1'b1;
            end else if (m_done) begin
                if (!REQ) m_done = 1'b0;
            end else if (REQ && (p == 3 || p == 5 || (p == 0 && !FETCH_EN))) begin
                e_cs = 1'b1; e_we = WE; e_addr = ADDR; e_wdata = DBI;
                m_issued = 1'b1; m_issued_rd = !WE;
                if (WE) shadow[ADDR] = DBI;
                else begin
                    m_rd_data = shadow[ADDR];
                    exp_q.push_back(shadow[ADDR]);
                end
            end
            m_blink = m_blink ^ sec_pulse;
            m_ph = (p + 1) % 8;
            e_ph2 = (m_ph == 7);
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ph2", ph2, e_ph2);
            chk("ack", ACK, e_ack);
            chk("mem_cs", MEM_CS, e_cs);
            chk("mem_we", MEM_WE, e_we);
            chk("mem_addr", MEM_ADDR, e_addr);
            chk("mem_wdata", MEM_WDATA, e_wdata);
            chk("vdi", VDI, e_vdi);
            chk("cursor", cursor, e_cursor);
            chk("dbo", DBO, e_dbo);
            if (ACK && ack_is_rd && exp_q.size() > 0) chk("dbo_sb", DBO, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_phase(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_ph != p && n < 16);
        if (m_ph != p) begin
            n_checks++; n_fail++;
            $display("FAIL wait_phase: phase %0d not reached, at %0d", p, m_ph);
        end
    endtask

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!ACK && cycles < 32);
        if (!ACK) begin
            n_checks++; n_fail++;
            $display("FAIL wait_ack: no ACK within %0d cycles, required 1", cycles);
        end
    endtask

    task automatic pulse_sec(input int n);
        sec_pulse = 1'b1;
        repeat (n) @(negedge clk);
        sec_pulse = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int acks, wrs, lat, c;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i] = 16'(i * 13 + 256);
            shadow[i] = vram[i];
        end
        vram[14'h0010] = 16'h1F41;  shadow[14'h0010] = 16'h1F41;
        vram[14'h0030] = 16'h5A5A;  shadow[14'h0030] = 16'h5A5A;
        vram[14'h0100] = 16'h0777;  shadow[14'h0100] = 16'h0777;

        // reset state and the basic fetch cadence
        FETCH_EN = 1'b1; MA = 14'h0010;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_vdi", VDI, 16'h0000);
        chk("rst_cs", MEM_CS, 0);
        chk("rst_ph2", ph2, 0);
        nRESET = 1'b1;
        @(negedge clk);
        chk("t1_cs", MEM_CS, 1);
        chk("t1_addr", MEM_ADDR, 14'h0010);
        @(negedge clk);
        chk("t1_vdi", VDI, 16'h1F41);
        wait_phase(7);
        chk("t1_ph2", ph2, 1);
        wait_phase(1);
        chk("t1_cs_rep", MEM_CS, 1);
        wait_phase(6);
        chk("t1_vdi_rep", VDI, 16'h1F41);
        chk("t1_ph2_low", ph2, 0);

        // held REQ write raised at phase 6: one access, 6-cycle latency
        CURS_EN = 1'b1; CURS_ADDR = 14'h0010; CURS_BLINK = 1'b0;
        ADDR = 14'h0020; DBI = 16'hBEEF; WE = 1'b1; REQ = 1'b1;
        acks = 0; wrs = 0; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ACK) begin
                acks++;
                if (lat < 0) lat = i - 1;
            end
            if (MEM_CS && MEM_WE) wrs++;
        end
        REQ = 1'b0;
        chk("t2_acks", acks, 1);
        chk("t2_writes", wrs, 1);
        chk("t2_latency", lat, 6);
        chk("t2_vram", vram[14'h0020], 16'hBEEF);
        @(negedge clk);
        WE = 1'b0; REQ = 1'b1;
        wait_ack(c);
        REQ = 1'b0;
        chk("t2_rd_dbo", DBO, 16'hBEEF);

        // blanked cell: phase 0 becomes a host slot, VDI/cursor cleared
        wait_phase(7);
        chk("t3_cur_before", cursor, 1);
        FETCH_EN = 1'b0; ADDR = 14'h0030; WE = 1'b0; REQ = 1'b1;
        wait_ack(c);
        REQ = 1'b0;
        chk("t3_latency", c - 1, 2);
        chk("t3_dbo", DBO, 16'h5A5A);
        chk("t3_vdi", VDI, 16'h0000);
        chk("t3_cursor", cursor, 0);

        // cursor blink
        FETCH_EN = 1'b1; MA = 14'h0100; CURS_ADDR = 14'h0100; CURS_EN = 1'b1; CURS_BLINK = 1'b1;
        wait_phase(2);
        chk("t4_vdi", VDI, 16'h0777);
        chk("t4_cur_on", cursor, 1);
        pulse_sec(1);
        wait_phase(2);
        chk("t4_cur_off", cursor, 0);
        wait_phase(2);
        chk("t4_cur_off2", cursor, 0);
        pulse_sec(1);
        wait_phase(2);
        chk("t4_cur_on2", cursor, 1);
        pulse_sec(2);
        wait_phase(2);
        chk("t4_cur_double", cursor, 1);
        CURS_BLINK = 1'b0;
        pulse_sec(1);
        wait_phase(2);
        chk("t4_steady", cursor, 1);
        wait_phase(2);
        chk("t4_steady2", cursor, 1);

        // same-cell write to the displayed address
        CURS_EN = 1'b0; MA = 14'h0010;
        wait_phase(2);
        chk("t5_vdi_pre", VDI, 16'h1F41);
        wait_phase(3);
        ADDR = 14'h0010; DBI = 16'h2222; WE = 1'b1; REQ = 1'b1;
        wait_ack(c);
        REQ = 1'b0;
        chk("t5_latency", c - 1, 1);
        wait_phase(6);
        chk("t5_vdi_old", VDI, 16'h1F41);
        wait_phase(2);
        chk("t5_vdi_new", VDI, 16'h2222);

        // reset during an in-flight host read
        wait_phase(3);
        ADDR = 14'h0020; WE = 1'b0; REQ = 1'b1;
        @(negedge clk);
        chk("t6_cs_inflight", MEM_CS, 1);
        #2 nRESET = 1'b0;
        #1;
        chk("t6_rst_ack", ACK, 0);
        chk("t6_rst_cs", MEM_CS, 0);
        chk("t6_rst_vdi", VDI, 16'h0000);
        chk("t6_rst_addr", MEM_ADDR, 14'h0000);
        repeat (2) begin
            @(negedge clk);
            chk("t6_rst_noack", ACK, 0);
        end
        nRESET = 1'b1;
        wait_ack(c);
        REQ = 1'b0;
        chk("t6_ack_after_release", c, 5);
        chk("t6_dbo", DBO, 16'hBEEF);
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
